// File: rtl/seg_scan_encoder_if.sv
// Load handshake and display-scan signals of the seg_scan_encoder.
// The master side offers digit banks and scan enable; the slave side drives the display.
interface seg_scan_encoder_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    en;
  logic                    wr_valid;
  logic [4*NUM_DIGITS-1:0] wr_data;
  logic                    wr_ready;
  logic [2:0]              v;
  logic [6:0]              seg;
  logic                    frame_start;

  modport master (
    output en, wr_valid, wr_data,
    input  wr_ready, v, seg, frame_start
  );

  modport slave (
    input  en, wr_valid, wr_data,
    output wr_ready, v, seg, frame_start
  );
endinterface

// File: rtl/seg_scan_encoder.sv
// Time-multiplexed 7-segment scan driver with a double-buffered digit bank.
// Emits select code v = index + 2 and the hex pattern of the selected digit.
module seg_scan_encoder #(
  parameter int NUM_DIGITS     = 6,
  parameter int TICK_DIV       = 100000,
  parameter bit ACTIVE_LOW_SEG = 1'b1
) (
  input logic              clk,
  input logic              rst,
  seg_scan_encoder_if.slave bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int              BW        = 4 * NUM_DIGITS;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [2:0]      LAST_IDX  = 3'(NUM_DIGITS - 1);
  localparam logic [2:0]      CODE_BASE = 3'b010;
  localparam logic [6:0]      BLANK     = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;

  state_t        state;
  logic [PW-1:0] presc;
  logic [2:0]    index;
  logic [BW-1:0] active;
  logic [BW-1:0] shadow;
  logic          shadow_full;
  logic [2:0]    v_q;
  logic [6:0]    seg_q;
  logic          frame_start_q;
  logic          accept;

  // Active-high hex pattern {g,f,e,d,c,b,a}, then polarity applied.
  function automatic logic [6:0] encode(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    return p ^ {7{ACTIVE_LOW_SEG}};
  endfunction

  function automatic logic [3:0] pick(input logic [BW-1:0] bank, input logic [2:0] idx);
    logic [3:0] n;
    n = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (idx == 3'(k)) n = bank[4*k +: 4];
    return n;
  endfunction

  // The shadow is free whenever nothing is pending; a pending bank blocks new writes.
  assign accept = bus.wr_valid && !shadow_full;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      presc         <= '0;
      index         <= '0;
      active        <= '0;
      shadow        <= '0;
      shadow_full   <= 1'b0;
      v_q           <= CODE_BASE;
      seg_q         <= BLANK;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;

      if (accept) begin
        shadow      <= bus.wr_data;
        shadow_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          presc <= '0;
          index <= '0;
          v_q   <= CODE_BASE;
          if (shadow_full) begin
            active      <= shadow;
            shadow_full <= 1'b0;
          end
          // Entering SCAN shows digit 0 at once, using the bank being copied this edge.
          if (bus.en) begin
            state <= SCAN;
            seg_q <= encode(pick(shadow_full ? shadow : active, 3'd0));
          end else begin
            seg_q <= BLANK;
          end
        end

        SCAN: begin
          if (!bus.en) begin
            state <= IDLE;
            presc <= '0;
            index <= '0;
            v_q   <= CODE_BASE;
            seg_q <= BLANK;
          end else if (presc == PRESC_MAX) begin
            presc <= '0;
            // Blank for one cycle while the select code moves, to avoid ghosting.
            seg_q <= BLANK;
            if (index == LAST_IDX) begin
              index         <= '0;
              v_q           <= CODE_BASE;
              frame_start_q <= 1'b1;
              if (shadow_full) begin
                active      <= shadow;
                shadow_full <= 1'b0;
              end
            end else begin
              index <= index + 3'd1;
              v_q   <= index + 3'd3;
            end
          end else begin
            presc <= presc + PW'(1);
            seg_q <= encode(pick(active, index));
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_ready    = ~shadow_full;
  assign bus.v           = v_q;
  assign bus.seg         = seg_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_encoder.sv
// Directed bench for seg_scan_encoder: 6 digits, 4-cycle dwell, active-low segments.
// Frame timing: digit d occupies cycles 4d..4d+3 after the entry or wrap edge.
module tb_seg_scan_encoder;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_encoder_if #(.NUM_DIGITS(6)) bus ();

  seg_scan_encoder #(
    .NUM_DIGITS    (6),
    .TICK_DIV      (4),
    .ACTIVE_LOW_SEG(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Hand-computed active-low patterns for hex digits 0..F.
  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40;  4'h1: p = 7'h79;  4'h2: p = 7'h24;  4'h3: p = 7'h30;
      4'h4: p = 7'h19;  4'h5: p = 7'h12;  4'h6: p = 7'h02;  4'h7: p = 7'h78;
      4'h8: p = 7'h00;  4'h9: p = 7'h10;  4'hA: p = 7'h08;  4'hB: p = 7'h03;
      4'hC: p = 7'h46;  4'hD: p = 7'h21;  4'hE: p = 7'h06;  default: p = 7'h0E;
    endcase
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.en = 1'b1; bus.wr_valid = 1'b0; bus.wr_data = '0;
    step(); step();
    n_checks++; if (bus.v !== 3'b010) begin n_fail++; $display("FAIL reset_v got %b want 010", bus.v); end
    n_checks++; if (bus.seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h want 7f", bus.seg); end
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); end
    n_checks++; if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got %b want 0", bus.frame_start); end
    rst = 1'b0; bus.en = 1'b0;
    step();
    n_checks++; if (bus.seg !== 7'h7F) begin n_fail++; $display("FAIL idle_seg got %h want 7f", bus.seg); end
  endtask

  task automatic test_scan_order();
    logic [23:0] bank;
    logic [6:0]  es;
    int          pulses;
    bank = 24'h543210;
    bus.wr_data = bank; bus.wr_valid = 1'b1;
    step();
    n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL idle_load_busy got %b want 0", bus.wr_ready); end
    bus.wr_valid = 1'b0;
    step();
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL idle_copy_ready got %b want 1", bus.wr_ready); end
    bus.en = 1'b1;
    step();
    for (int c = 0; c < 24; c++) begin
      es = ((c % 4) == 0 && c != 0) ? 7'h7F : exp_seg(bank[4*(c/4) +: 4]);
      n_checks++; if (bus.v !== 3'(c/4 + 2)) begin n_fail++; $display("FAIL scan_v c=%0d got %b want %b", c, bus.v, 3'(c/4 + 2)); end
      n_checks++; if (bus.seg !== es) begin n_fail++; $display("FAIL scan_seg c=%0d got %h want %h", c, bus.seg, es); end
      n_checks++; if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL scan_fs c=%0d got %b want 0", c, bus.frame_start); end
      step();
    end
    n_checks++; if (bus.v !== 3'b010) begin n_fail++; $display("FAIL wrap_v got %b want 010", bus.v); end
    n_checks++; if (bus.seg !== 7'h7F) begin n_fail++; $display("FAIL wrap_seg got %h want 7f", bus.seg); end
    n_checks++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL wrap_fs got %b want 1", bus.frame_start); end
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      if (bus.frame_start === 1'b1) pulses++;
      step();
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL fs_per_frame got %0d want 1", pulses); end
  endtask

  task automatic test_double_buffer();
    logic [23:0] old_bank;
    logic [6:0]  es;
    old_bank = 24'h543210;
    for (int c = 0; c < 6; c++) step();
    bus.wr_data = 24'hFFFFFF; bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    for (int c = 7; c < 24; c++) begin
      es = ((c % 4) == 0) ? 7'h7F : exp_seg(old_bank[4*(c/4) +: 4]);
      n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL db_busy c=%0d got %b want 0", c, bus.wr_ready); end
      n_checks++; if (bus.seg !== es) begin n_fail++; $display("FAIL db_old_seg c=%0d got %h want %h", c, bus.seg, es); end
      step();
    end
    n_checks++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL db_wrap_fs got %b want 1", bus.frame_start); end
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL db_wrap_ready got %b want 1", bus.wr_ready); end
    for (int c = 0; c < 24; c++) begin
      es = ((c % 4) == 0) ? 7'h7F : 7'h0E;
      n_checks++; if (bus.seg !== es) begin n_fail++; $display("FAIL db_new_seg c=%0d got %h want %h", c, bus.seg, es); end
      step();
    end
  endtask

  task automatic test_back_pressure();
    logic [6:0] es;
    step(); step();
    bus.wr_data = 24'h333333; bus.wr_valid = 1'b1;
    step();
    bus.wr_data = 24'h111111;
    for (int c = 3; c < 10; c++) begin
      n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_busy c=%0d got %b want 0", c, bus.wr_ready); end
      step();
    end
    bus.wr_valid = 1'b0;
    for (int c = 10; c < 24; c++) step();
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_wrap_ready got %b want 1", bus.wr_ready); end
    n_checks++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL bp_wrap_fs got %b want 1", bus.frame_start); end
    for (int c = 0; c < 24; c++) begin
      es = ((c % 4) == 0) ? 7'h7F : 7'h30;
      n_checks++; if (bus.seg !== es) begin n_fail++; $display("FAIL bp_first_write c=%0d got %h want %h", c, bus.seg, es); end
      if (c == 23) begin bus.wr_data = 24'h999999; bus.wr_valid = 1'b1; end
      step();
    end
    bus.wr_valid = 1'b0;
    n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_write_taken got %b want 0", bus.wr_ready); end
    n_checks++; if (bus.frame_start !== 1'b1) begin n_fail++; $display("FAIL wrap_write_fs got %b want 1", bus.frame_start); end
    for (int c = 0; c < 24; c++) begin
      es = ((c % 4) == 0) ? 7'h7F : 7'h30;
      n_checks++; if (bus.seg !== es) begin n_fail++; $display("FAIL wrap_write_delay c=%0d got %h want %h", c, bus.seg, es); end
      step();
    end
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_write_ready got %b want 1", bus.wr_ready); end
    for (int c = 0; c < 24; c++) begin
      es = ((c % 4) == 0) ? 7'h7F : 7'h10;
      n_checks++; if (bus.seg !== es) begin n_fail++; $display("FAIL wrap_write_show c=%0d got %h want %h", c, bus.seg, es); end
      step();
    end
  endtask

  task automatic test_enable_drop();
    for (int c = 0; c < 13; c++) step();
    n_checks++; if (bus.v !== 3'b101) begin n_fail++; $display("FAIL drop_pre_v got %b want 101", bus.v); end
    bus.en = 1'b0;
    step();
    n_checks++; if (bus.seg !== 7'h7F) begin n_fail++; $display("FAIL drop_seg got %h want 7f", bus.seg); end
    n_checks++; if (bus.v !== 3'b010) begin n_fail++; $display("FAIL drop_v got %b want 010", bus.v); end
    n_checks++; if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL drop_fs got %b want 0", bus.frame_start); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus.seg !== 7'h7F) begin n_fail++; $display("FAIL idle_hold_seg i=%0d got %h want 7f", i, bus.seg); end
    end
    bus.en = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (bus.v !== ((c < 4) ? 3'b010 : 3'b011)) begin n_fail++; $display("FAIL reen_v c=%0d got %b", c, bus.v); end
      n_checks++; if (bus.seg !== ((c < 4) ? 7'h10 : 7'h7F)) begin n_fail++; $display("FAIL reen_seg c=%0d got %h", c, bus.seg); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] es;
    bus.wr_data = 24'h777777; bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL rm_pending got %b want 0", bus.wr_ready); end
    for (int c = 6; c < 17; c++) step();
    n_checks++; if (bus.v !== 3'b110) begin n_fail++; $display("FAIL rm_index4_v got %b want 110", bus.v); end
    rst = 1'b1;
    step();
    n_checks++; if (bus.v !== 3'b010) begin n_fail++; $display("FAIL rm_v got %b want 010", bus.v); end
    n_checks++; if (bus.seg !== 7'h7F) begin n_fail++; $display("FAIL rm_seg got %h want 7f", bus.seg); end
    n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready got %b want 1", bus.wr_ready); end
    n_checks++; if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL rm_fs got %b want 0", bus.frame_start); end
    rst = 1'b0;
    step();
    for (int c = 0; c < 28; c++) begin
      es = ((c % 4) == 0 && c != 0) ? 7'h7F : 7'h40;
      n_checks++; if (bus.seg !== es) begin n_fail++; $display("FAIL rm_zero_bank c=%0d got %h want %h", c, bus.seg, es); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_double_buffer();
    test_back_pressure();
    test_enable_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
